// File: rtl/gpio_int_ctrl_pkg.sv
// gpio_int_ctrl_pkg
//   Shared GPIO constants for the pin-side interrupt engine: default pin
//   count, debounce defaults, counter width and the type/polarity encodings.
//   The optional both-edge feature is switched by the GPIO_INT_BOTHEDGE_EN
//   macro, which is tested in rtl/gpio_int_ctrl.sv.
package gpio_int_ctrl_pkg;

  localparam int GPIO_PWIDTH   = 8;
  localparam int GPIO_DB_DIV   = 16;
  localparam int GPIO_DB_CNT   = 3;
  // Wide enough for the largest legal DB_CNT (7)
  localparam int GPIO_DB_CNT_W = 3;

  // gpio_int_type encoding (1 = edge, 0 = level)
  localparam logic GPIO_TYPE_EDGE = 1'b1;
  // gpio_int_pol encoding (1 = active-high / rising, 0 = active-low / falling)
  localparam logic GPIO_POL_HIGH  = 1'b1;

  // Single-pin edge event for the selected polarity
  function automatic logic gpio_edge_evt(input logic filt, input logic prev,
                                         input logic pol);
    if (pol == GPIO_POL_HIGH) return filt & ~prev;
    else                      return ~filt & prev;
  endfunction

  // Single-pin level activity for the selected polarity
  function automatic logic gpio_level_act(input logic filt, input logic pol);
    return (pol == GPIO_POL_HIGH) ? filt : ~filt;
  endfunction

endpackage

// File: rtl/gpio_debounce_cell.sv
// gpio_debounce_cell
//   Single-pin debounce filter fed by the synchroniser output. When enabled,
//   the filtered value only changes after DB_CNT consecutive prescaler ticks
//   that see the synchronised pin differing from the filtered value. When
//   disabled, the filtered value follows the input every cycle.
// Ports:
//   pclk, presetn  clock / asynchronous active-low reset
//   sync_in        synchronised pin value
//   tick           one-cycle debounce sample strobe from the prescaler
//   db_en          1 = filter active for this pin
//   filt           filtered pin value
module gpio_debounce_cell
  import gpio_int_ctrl_pkg::*;
#(
  parameter int DB_CNT = GPIO_DB_CNT
) (
  input  logic pclk,
  input  logic presetn,
  input  logic sync_in,
  input  logic tick,
  input  logic db_en,
  output logic filt
);

  localparam logic [GPIO_DB_CNT_W-1:0] CNT_MAX = GPIO_DB_CNT_W'(DB_CNT);

  logic [GPIO_DB_CNT_W-1:0] cnt;
  logic [GPIO_DB_CNT_W-1:0] cnt_inc;

  // Increment that never passes DB_CNT
  function automatic logic [GPIO_DB_CNT_W-1:0] sat_inc(
    input logic [GPIO_DB_CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  assign cnt_inc = sat_inc(cnt);

  // Filter stage: disabling the filter forces the counter back to 0, so
  // re-enabling it always starts a fresh qualification window.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (!db_en) begin
      filt <= sync_in;
      cnt  <= '0;
    end else if (tick) begin
      if (sync_in != filt) begin
        if (cnt_inc == CNT_MAX) begin
          filt <= sync_in;
          cnt  <= '0;
        end else begin
          cnt  <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_int_ctrl.sv
// gpio_int_ctrl
//   Pin-side interrupt and input-conditioning engine for the GPIO block.
//   Synchronises pads (2 flops), optionally debounces them, detects edges /
//   levels per the per-pin configuration and produces raw and masked status
//   plus registered interrupt outputs.
//   Optional feature macro: GPIO_INT_BOTHEDGE_EN adds gpio_int_bothedge; an
//   edge pin with that bit set triggers on both edges regardless of polarity.
// Ports:
//   pclk, presetn          clock / asynchronous active-low reset
//   gpio_ext_porta         raw asynchronous pad inputs
//   gpio_int_en/mask/type/pol/debounce  per-pin configuration
//   gpio_int_clr           write-1-to-clear pulses for edge status
//   gpio_int_level_sync    1 = level status delayed by one extra pclk
//   gpio_int_bothedge      (optional) per-pin both-edge select
//   gpio_ext_data          synchronised pad values
//   gpio_raw_int_status    unmasked status
//   gpio_int_status        raw & ~mask
//   gpio_intr              registered per-pin interrupt
//   gpio_intr_flag         registered OR of gpio_int_status
module gpio_int_ctrl
  import gpio_int_ctrl_pkg::*;
#(
  parameter int PWIDTH = GPIO_PWIDTH,
  parameter int DB_DIV = GPIO_DB_DIV,
  parameter int DB_CNT = GPIO_DB_CNT
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [PWIDTH-1:0] gpio_ext_porta,
  input  logic [PWIDTH-1:0] gpio_int_en,
  input  logic [PWIDTH-1:0] gpio_int_mask,
  input  logic [PWIDTH-1:0] gpio_int_type,
  input  logic [PWIDTH-1:0] gpio_int_pol,
  input  logic [PWIDTH-1:0] gpio_debounce,
  input  logic [PWIDTH-1:0] gpio_int_clr,
  input  logic              gpio_int_level_sync,
`ifdef GPIO_INT_BOTHEDGE_EN
  input  logic [PWIDTH-1:0] gpio_int_bothedge,
`endif
  output logic [PWIDTH-1:0] gpio_ext_data,
  output logic [PWIDTH-1:0] gpio_raw_int_status,
  output logic [PWIDTH-1:0] gpio_int_status,
  output logic [PWIDTH-1:0] gpio_intr,
  output logic              gpio_intr_flag
);

  localparam int PS_W = $clog2(DB_DIV);

  logic [PS_W-1:0]   ps_cnt;
  logic              db_tick;
  logic [PWIDTH-1:0] sync_p0, sync_p1;
  logic [PWIDTH-1:0] filt_p2, prev_p3;
  logic [PWIDTH-1:0] edge_pin, edge_evt, lvl_now, lvl_q;
  logic [PWIDTH-1:0] sticky, sticky_nxt;

  // Prescaler: free-running debounce sample strobe
  assign db_tick = (ps_cnt == PS_W'(DB_DIV - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) ps_cnt <= '0;
    else          ps_cnt <= db_tick ? '0 : ps_cnt + 1'b1;
  end

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= gpio_ext_porta;
      sync_p1 <= sync_p0;
    end
  end

  assign gpio_ext_data = sync_p1;

  // Stage p2: per-pin debounce filter
  for (genvar i = 0; i < PWIDTH; i++) begin : g_pin
    gpio_debounce_cell #(
      .DB_CNT (DB_CNT)
    ) u_db (
      .pclk    (pclk),
      .presetn (presetn),
      .sync_in (sync_p1[i]),
      .tick    (db_tick),
      .db_en   (gpio_debounce[i]),
      .filt    (filt_p2[i])
    );

    assign edge_pin[i] = (gpio_int_type[i] == GPIO_TYPE_EDGE);
`ifdef GPIO_INT_BOTHEDGE_EN
    assign edge_evt[i] = gpio_int_bothedge[i] ? (filt_p2[i] ^ prev_p3[i])
                       : gpio_edge_evt(filt_p2[i], prev_p3[i], gpio_int_pol[i]);
`else
    assign edge_evt[i] = gpio_edge_evt(filt_p2[i], prev_p3[i], gpio_int_pol[i]);
`endif
    assign lvl_now[i]  = gpio_int_en[i] & ~edge_pin[i]
                       & gpio_level_act(filt_p2[i], gpio_int_pol[i]);
  end

  // Set has priority over clear; disabled or level pins hold no sticky state.
  assign sticky_nxt = edge_pin & gpio_int_en & (edge_evt | (sticky & ~gpio_int_clr));

  // Stage p3: previous filtered value, sticky edge bits, delayed level
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prev_p3 <= '0;
      sticky  <= '0;
      lvl_q   <= '0;
    end else begin
      prev_p3 <= filt_p2;
      sticky  <= sticky_nxt;
      lvl_q   <= lvl_now;
    end
  end

  // ~edge_pin guards against a stale lvl_q right after a type change
  assign gpio_raw_int_status = sticky
                             | (~edge_pin & (gpio_int_level_sync ? lvl_q : lvl_now));
  assign gpio_int_status     = gpio_raw_int_status & ~gpio_int_mask;

  // Stage p4: registered interrupt outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      gpio_intr      <= '0;
      gpio_intr_flag <= 1'b0;
    end else begin
      gpio_intr      <= gpio_int_status;
      gpio_intr_flag <= |gpio_int_status;
    end
  end

endmodule

// File: tb/tb_gpio_int_ctrl.sv
module tb_gpio_int_ctrl;

  localparam int PW = 8;

  logic          pclk;
  logic          presetn;
  logic [PW-1:0] pads, en, mask, typ, pol, deb, clr;
  logic          lsync;
`ifdef GPIO_INT_BOTHEDGE_EN
  logic [PW-1:0] both;
`endif
  logic [PW-1:0] ext_data, raw, status, intr;
  logic          flag;

  int checks = 0;
  int errors = 0;

  gpio_int_ctrl #(
    .PWIDTH (PW),
    .DB_DIV (4),
    .DB_CNT (3)
  ) dut (
    .pclk                (pclk),
    .presetn             (presetn),
    .gpio_ext_porta      (pads),
    .gpio_int_en         (en),
    .gpio_int_mask       (mask),
    .gpio_int_type       (typ),
    .gpio_int_pol        (pol),
    .gpio_debounce       (deb),
    .gpio_int_clr        (clr),
    .gpio_int_level_sync (lsync),
`ifdef GPIO_INT_BOTHEDGE_EN
    .gpio_int_bothedge   (both),
`endif
    .gpio_ext_data       (ext_data),
    .gpio_raw_int_status (raw),
    .gpio_int_status     (status),
    .gpio_intr           (intr),
    .gpio_intr_flag      (flag)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic cfg(input logic [PW-1:0] e, input logic [PW-1:0] t,
                     input logic [PW-1:0] p, input logic [PW-1:0] m,
                     input logic [PW-1:0] d);
    en = e; typ = t; pol = p; mask = m; deb = d;
  endtask

  task automatic test_reset;
    pads = 8'hFF;
    #3 presetn = 1'b0;
    cyc(3);
    checks++;
    if ({ext_data, raw, status, intr, flag} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs got ext=%h raw=%h st=%h intr=%h flag=%b exp all 0",
               ext_data, raw, status, intr, flag);
    end
    pads = 8'h00;
    presetn = 1'b1;
    cyc(5);
    checks++;
    if (raw !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_raw got %h exp 00", raw);
    end
  endtask

  task automatic test_rising_edge;
    cfg(8'h01, 8'h01, 8'h01, 8'h00, 8'h00);
    cyc(3);
    pads[0] = 1'b1;
    cyc(1);
    checks++;
    if (ext_data[0] !== 1'b0) begin
      errors++; $display("FAIL edge_ext_lat1 got %b exp 0", ext_data[0]);
    end
    cyc(1);
    checks++;
    if (ext_data[0] !== 1'b1) begin
      errors++; $display("FAIL edge_ext_lat2 got %b exp 1", ext_data[0]);
    end
    cyc(1);
    checks++;
    if (raw[0] !== 1'b0) begin
      errors++; $display("FAIL edge_raw_early got %b exp 0", raw[0]);
    end
    cyc(1);
    checks++;
    if (raw[0] !== 1'b1 || intr[0] !== 1'b0) begin
      errors++; $display("FAIL edge_raw_set got raw=%b intr=%b exp raw=1 intr=0", raw[0], intr[0]);
    end
    cyc(1);
    checks++;
    if (intr[0] !== 1'b1 || flag !== 1'b1) begin
      errors++; $display("FAIL edge_intr got intr=%b flag=%b exp 1 1", intr[0], flag);
    end
    clr = 8'h01;
    cyc(1);
    clr = 8'h00;
    checks++;
    if (raw[0] !== 1'b0) begin
      errors++; $display("FAIL edge_clear got %b exp 0", raw[0]);
    end
    cyc(1);
    checks++;
    if (intr[0] !== 1'b0 || flag !== 1'b0) begin
      errors++; $display("FAIL edge_intr_clear got intr=%b flag=%b exp 0 0", intr[0], flag);
    end
  endtask

  task automatic test_collision;
    cfg(8'h04, 8'h04, 8'h04, 8'h00, 8'h00);
    cyc(2);
    pads[2] = 1'b1;
    cyc(3);
    checks++;
    if (raw[2] !== 1'b0) begin
      errors++; $display("FAIL coll_pre got %b exp 0", raw[2]);
    end
    clr = 8'h04;
    cyc(1);
    clr = 8'h00;
    checks++;
    if (raw[2] !== 1'b1) begin
      errors++; $display("FAIL coll_set_wins got %b exp 1", raw[2]);
    end
    clr = 8'h04;
    cyc(1);
    clr = 8'h00;
    checks++;
    if (raw[2] !== 1'b0) begin
      errors++; $display("FAIL coll_clear_after got %b exp 0", raw[2]);
    end
  endtask

  task automatic test_level;
    cfg(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
    lsync = 1'b0;
    cyc(2);
    checks++;
    if (raw[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_low_active got %b exp 1", raw[3]);
    end
    pads[3] = 1'b1;
    cyc(2);
    checks++;
    if (raw[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_deassert_early got %b exp 1", raw[3]);
    end
    cyc(1);
    checks++;
    if (raw[3] !== 1'b0) begin
      errors++; $display("FAIL lvl_deassert got %b exp 0", raw[3]);
    end
    pads[3] = 1'b0;
    cyc(3);
    checks++;
    if (raw[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_assert got %b exp 1", raw[3]);
    end
    clr = 8'h08;
    cyc(1);
    clr = 8'h00;
    checks++;
    if (raw[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_clr_ignored got %b exp 1", raw[3]);
    end
    lsync = 1'b1;
    cyc(2);
    pads[3] = 1'b1;
    cyc(3);
    checks++;
    if (raw[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_sync_deassert_early got %b exp 1", raw[3]);
    end
    cyc(1);
    checks++;
    if (raw[3] !== 1'b0) begin
      errors++; $display("FAIL lvl_sync_deassert got %b exp 0", raw[3]);
    end
    pads[3] = 1'b0;
    cyc(3);
    checks++;
    if (raw[3] !== 1'b0) begin
      errors++; $display("FAIL lvl_sync_assert_early got %b exp 0", raw[3]);
    end
    cyc(1);
    checks++;
    if (raw[3] !== 1'b1) begin
      errors++; $display("FAIL lvl_sync_assert got %b exp 1", raw[3]);
    end
    lsync = 1'b0;
    pads[3] = 1'b1;
    cyc(4);
  endtask

  task automatic test_debounce;
    cfg(8'h02, 8'h02, 8'h02, 8'h00, 8'h02);
    cyc(2);
    pads[1] = 1'b1;
    cyc(2);
    checks++;
    if (ext_data[1] !== 1'b1) begin
      errors++; $display("FAIL db_ext_data got %b exp 1", ext_data[1]);
    end
    cyc(4);
    checks++;
    if (raw[1] !== 1'b0) begin
      errors++; $display("FAIL db_too_early got %b exp 0", raw[1]);
    end
    cyc(14);
    checks++;
    if (raw[1] !== 1'b1) begin
      errors++; $display("FAIL db_stable_high got %b exp 1", raw[1]);
    end
    clr = 8'h02;
    cyc(1);
    clr = 8'h00;
    pads[1] = 1'b0;
    cyc(3);
    checks++;
    if (ext_data[1] !== 1'b0) begin
      errors++; $display("FAIL db_glitch_seen got %b exp 0", ext_data[1]);
    end
    cyc(3);
    pads[1] = 1'b1;
    cyc(20);
    checks++;
    if (raw[1] !== 1'b0) begin
      errors++; $display("FAIL db_glitch_filtered got %b exp 0", raw[1]);
    end
  endtask

  task automatic test_mask;
    cfg(8'h10, 8'h10, 8'h10, 8'h10, 8'h00);
    cyc(2);
    pads[4] = 1'b1;
    cyc(6);
    checks++;
    if (raw[4] !== 1'b1 || status[4] !== 1'b0 || flag !== 1'b0 || intr !== 8'h00) begin
      errors++;
      $display("FAIL mask_pending got raw=%b st=%b flag=%b intr=%h exp 1 0 0 00",
               raw[4], status[4], flag, intr);
    end
    mask = 8'h00;
    #1;
    checks++;
    if (status[4] !== 1'b1 || flag !== 1'b0) begin
      errors++; $display("FAIL mask_unmask_status got st=%b flag=%b exp 1 0", status[4], flag);
    end
    cyc(1);
    checks++;
    if (flag !== 1'b1 || intr[4] !== 1'b1) begin
      errors++; $display("FAIL mask_unmask_intr got flag=%b intr=%b exp 1 1", flag, intr[4]);
    end
  endtask

  task automatic test_reset_mid;
    cfg(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00);
    pads = 8'h00;
    cyc(5);
    clr = 8'hFF;
    cyc(1);
    clr = 8'h00;
    pads = 8'hFF;
    cyc(5);
    checks++;
    if (raw !== 8'hFF) begin
      errors++; $display("FAIL rst_pending_all got %h exp ff", raw);
    end
    deb = 8'hFF;
    pads = 8'h00;
    cyc(7);
    checks++;
    if (raw !== 8'hFF || ext_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_filter got raw=%h ext=%h exp ff 00", raw, ext_data);
    end
    #3 presetn = 1'b0;
    #1;
    checks++;
    if ({ext_data, raw, status, intr, flag} !== 33'd0) begin
      errors++;
      $display("FAIL rst_async got ext=%h raw=%h st=%h intr=%h flag=%b exp all 0",
               ext_data, raw, status, intr, flag);
    end
    en = 8'h00;
    deb = 8'h00;
    pads = 8'hFF;
    cyc(1);
    presetn = 1'b1;
    cyc(10);
    checks++;
    if (raw !== 8'h00 || flag !== 1'b0 || ext_data !== 8'hFF) begin
      errors++; $display("FAIL rst_release got raw=%h flag=%b ext=%h exp 00 0 ff", raw, flag, ext_data);
    end
    en = 8'hFF;
    cyc(3);
    checks++;
    if (raw !== 8'h00 || flag !== 1'b0) begin
      errors++; $display("FAIL rst_no_spurious got raw=%h flag=%b exp 00 0", raw, flag);
    end
  endtask

  initial begin
    presetn = 1'b1;
    pads = '0; clr = '0; lsync = 1'b0;
    cfg('0, '0, '0, '0, '0);
`ifdef GPIO_INT_BOTHEDGE_EN
    both = '0;
`endif
    test_reset();
    test_rising_edge();
    test_collision();
    test_level();
    test_debounce();
    test_mask();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
